mult_div: RTL and testbench
===========================

# mult_div

Multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It executes `mult`, `multu`, `div` and `divu` over a fixed multi-cycle latency, holds the HI/LO architectural registers, and services `mthi`/`mtlo` writes and `mfhi`/`mflo` reads. It drives the `State` and `Busy` signals that the hazard unit consumes to stall HI/LO-dependent instructions in ID.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk` input 1: the single clock; rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `A` input 32: rs operand, forwarded value from EX.
- `B` input 32: rt operand, forwarded value from EX.
- `MDOp` input 2: operation select. 00 = mult, 01 = multu, 10 = div, 11 = divu.
- `Start` input 1: one-cycle pulse while an MD instruction occupies EX.
- `Kill` input 1: exception or interrupt taken this cycle. Cancels `Start`, `HiWrite` and `LoWrite` in the same cycle.
- `HiWrite` input 1: `mthi`; HI ← `A`.
- `LoWrite` input 1: `mtlo`; LO ← `A`.
- `State` output 1: `Start & ~Kill & ~Busy`, combinational.
- `Busy` output 1: registered; high while an operation is in progress.
- `Hi` output 32: HI register, registered.
- `Lo` output 32: LO register, registered.

## Operation
- Two-state FSM: IDLE and RUN. A 4-bit down-counter `cnt` runs in RUN.
- **Accepted start.** In IDLE with `State`=1, at the edge:
  - latch `MDOp`;
  - latch the result computed from `A`/`B` that cycle (64-bit product, or quotient/remainder);
  - load `cnt` with N−1, where N is `MULT_CYCLES` for ops 0x/01 and `DIV_CYCLES` for ops 1x;
  - go to RUN.
- **RUN.** `cnt` decrements each cycle. On the edge where `cnt`==0:
  - commit the result: mult/multu give HI = product[63:32], LO = product[31:0];
  - div/divu give LO = quotient, HI = remainder;
  - return to IDLE.
- Arithmetic:
  - signed ops use two's complement; quotient truncates toward zero; the remainder takes the sign of the dividend;
  - 0x80000000 / −1 gives LO = 0x80000000, HI = 0.
- Divide by zero (B = 0): the op runs its full latency and commits nothing. HI and LO stay unchanged.
- `Start` while `Busy`: ignored, with no restart and no latch. This case is a hazard-unit bug and is flagged by a bench assertion.
- `HiWrite`/`LoWrite`:
  - take effect at the edge only when `~Busy & ~Kill`; they are ignored while `Busy`;
  - both may be asserted together;
  - `Start` together with an `mthi`/`mtlo` write cannot occur (single-issue pipeline).
- `Kill` during RUN does not abort. The in-flight op was issued by an older, committed instruction and completes normally.
- Reset, including mid-operation:
  - FSM goes to IDLE; `cnt`=0; `Busy`=0;
  - `Hi`=0, `Lo`=0;
  - latched result and op are discarded.

## Timing
- Cycle T: `Start` with no `Kill` makes `State`=1 in cycle T, combinationally. The hazard unit stalls on it the same cycle.
- T+1 … T+N: `Busy`=1.
- End of T+N: HI/LO are written.
- T+N+1: `Busy`=0 and the new `Hi`/`Lo` are visible. An `mfhi` released from stall in ID reads them through EX with no bypass needed.
- `mthi`/`mtlo`: written at the edge ending the cycle in which they are asserted; visible the next cycle.
- Back-to-back ops: a second `Start` is accepted at T+N+1 at the earliest.

## Structure
- Shared package `md_pkg` holds:
  - the `MDOp` encoding constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the default latencies;
  - the FSM state encoding.
- Sub-module `md_calc` is purely combinational. It takes `A`, `B` and `MDOp` and produces the 64-bit `{hi, lo}` result and a `div0` flag. `mult_div` holds the FSM, counter, result latch and HI/LO registers.

## Test plan
- `mult`, A=0xFFFFFFFF, B=2, `Start` at T → `State`=1 at T; `Busy` high T+1..T+5; at T+6 `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFFE.
- `multu`, same operands → at T+6 `Hi`=0x00000001, `Lo`=0xFFFFFFFE.
- `div`, A=0xFFFFFFF9 (−7), B=2 → `Busy` high for 10 cycles; then `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF.
- Preload `Hi`=0x11, `Lo`=0x22 via mthi/mtlo; then `divu` A=7, B=0 → `Busy` high for 10 cycles; `Hi`/`Lo` still 0x11/0x22.
- `Start` with `Kill`=1 → `State`=0, `Busy` stays 0. `mthi` A=0x55 with `Kill`=1 → `Hi` unchanged. `mthi` during `Busy` → ignored.
- `mult` 3×4 started, then `reset` asserted at T+3 → `Busy`=0, `Hi`=`Lo`=0 immediately. After release, `Start` is accepted again with a full 5-cycle latency.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default
// latencies and FSM state encoding.
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Divide ops are the ones with the upper op bit set.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // mult and div treat their operands as two's complement.
  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath. Produces the value that will be
// committed as {HI, LO}: product for multiplies, {remainder, quotient} for
// divides. div0 flags a zero divisor so the caller can suppress the commit.
module md_calc
  import md_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  md_op,
  output logic [63:0] result,
  output logic        div0
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;

  // Sign-magnitude divide so that INT_MIN / -1 wraps to INT_MIN without
  // relying on the simulator's signed-overflow behaviour.
  always_comb begin
    a_neg   = md_is_signed(md_op) & a[31];
    b_neg   = md_is_signed(md_op) & b[31];
    a_mag   = a_neg ? (32'd0 - a) : a;
    b_mag   = b_neg ? (32'd0 - b) : b;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;

    a_ext   = {{32{a_neg}}, a};
    b_ext   = {{32{b_neg}}, b};
    product = a_ext * b_ext;

    div0    = (b == 32'd0);
    result  = md_is_div(md_op) ? {rem, quot} : product;
  end

endmodule

// File: rtl/mult_div.sv
// EX-stage multiply/divide unit with HI/LO registers. The result is computed
// on the accepting edge and held for a fixed latency before committing, so
// the hazard unit sees a deterministic Busy window.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   MD_IDLE | no op in flight; accepts Start and mthi/mtlo writes
//   MD_RUN  | op in flight; cnt counts down, commit on cnt == 0
module mult_div
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  MDOp,
  input  logic        Start,
  input  logic        Kill,
  input  logic        HiWrite,
  input  logic        LoWrite,
  output logic        State,
  output logic        Busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] res_q, res_d;
  logic        div0_q, div0_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] calc_res;
  logic        calc_div0;

  md_calc u_calc (
    .a      (A),
    .b      (B),
    .md_op  (MDOp),
    .result (calc_res),
    .div0   (calc_div0)
  );

  assign State = Start & ~Kill & ~busy_q;
  assign Busy  = busy_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;

  // Next-state, counter, result latch and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    div0_d  = div0_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (~busy_q & ~Kill & HiWrite) hi_d = A;
    if (~busy_q & ~Kill & LoWrite) lo_d = A;

    unique case (state_q)
      MD_IDLE: begin
        if (State) begin
          op_d    = MDOp;
          res_d   = calc_res;
          div0_d  = calc_div0;
          cnt_d   = md_is_div(MDOp) ? DIV_LOAD : MULT_LOAD;
          busy_d  = 1'b1;
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        if (cnt_q == 4'd0) begin
          // A zero divisor burns the full latency but leaves HI/LO intact.
          if (!(md_is_div(op_q) && div0_q)) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
          busy_d  = 1'b0;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= MD_MULT;
      res_q   <= 64'd0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: the driver pushes the expected HI/LO and
// busy length of each op; a monitor pops and compares when Busy falls.
module tb_mult_div;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [1:0]  MDOp;
  logic        Start, Kill, HiWrite, LoWrite;
  logic        State, Busy;
  logic [31:0] Hi, Lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          bcnt = 0;
  bit          bprev = 1'b0;

  mult_div #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .MDOp    (MDOp),
    .Start   (Start),
    .Kill    (Kill),
    .HiWrite (HiWrite),
    .LoWrite (LoWrite),
    .State   (State),
    .Busy    (Busy),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, C-style truncating division.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_, p, q, r;
    logic [63:0] v, qv, rv;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb_; v = p; m_hi = v[63:32]; m_lo = v[31:0]; end
      2'b01: begin v = {32'd0, a} * {32'd0, b}; m_hi = v[63:32]; m_lo = v[31:0]; end
      2'b10: if (b != 0) begin
        q = sa / sb_; r = sa % sb_; qv = q; rv = r;
        m_lo = qv[31:0]; m_hi = rv[31:0];
      end
      default: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
    endcase
  endtask

  // Monitor: one scoreboard entry per Busy window.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      bcnt  = 0;
      bprev = 1'b0;
    end else begin
      if (Busy) bcnt++;
      if (bprev && !Busy) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("res_hi", {32'd0, Hi}, {32'd0, e.hi});
          chk("res_lo", {32'd0, Lo}, {32'd0, e.lo});
          chk("busy_len", 64'(bcnt), 64'(e.cyc));
        end
        bcnt = 0;
      end
      bprev = Busy;
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit mid_write);
    exp_t e;
    int   n;
    @(negedge clk);
    A = a; B = b; MDOp = op; Start = 1'b1;
    #1 chk("state_on_start", {63'd0, State}, 64'd1);
    model_op(op, a, b);
    e.hi = m_hi; e.lo = m_lo; e.cyc = op[1] ? DC : MC;
    sb.push_back(e);
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom; MDOp = 2'($urandom);
    chk("busy_after_start", {63'd0, Busy}, 64'd1);
    if (mid_write) begin
      HiWrite = 1'b1; LoWrite = 1'b1;
      @(negedge clk);
      HiWrite = 1'b0; LoWrite = 1'b0;
    end
    n = 0;
    while (Busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (Busy) begin
      $display("FAIL busy_timeout: Busy still 1 after %0d cycles, expected 0", n);
      $fatal(1, "busy timeout");
    end
  endtask

  task automatic do_mt(input bit hw, input bit lw, input bit kill, input logic [31:0] val);
    @(negedge clk);
    A = val; HiWrite = hw; LoWrite = lw; Kill = kill;
    if (!kill) begin
      if (hw) m_hi = val;
      if (lw) m_lo = val;
    end
    @(negedge clk);
    HiWrite = 1'b0; LoWrite = 1'b0; Kill = 1'b0;
    chk("mt_hi", {32'd0, Hi}, {32'd0, m_hi});
    chk("mt_lo", {32'd0, Lo}, {32'd0, m_lo});
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1; A = 0; B = 0; MDOp = 0;
    Start = 0; Kill = 0; HiWrite = 0; LoWrite = 0;
    #12;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_hi", {32'd0, Hi}, 64'd0);
    chk("rst_lo", {32'd0, Lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_mt(1'b1, 1'b0, 1'b0, 32'h11);
    do_mt(1'b0, 1'b1, 1'b0, 32'h22);
    do_op(2'b11, 32'd7, 32'd0, 1'b0);
    chk("div0_hi_kept", {32'd0, Hi}, 64'h11);
    chk("div0_lo_kept", {32'd0, Lo}, 64'h22);

    // Start cancelled by Kill.
    @(negedge clk);
    A = 32'd3; B = 32'd4; MDOp = 2'b00; Start = 1'b1; Kill = 1'b1;
    #1 chk("state_killed", {63'd0, State}, 64'd0);
    @(negedge clk);
    Start = 1'b0; Kill = 1'b0;
    chk("busy_killed", {63'd0, Busy}, 64'd0);
    do_mt(1'b1, 1'b0, 1'b1, 32'h55);

    // mthi/mtlo while busy must be ignored; result commits over them.
    do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    A = 32'd3; B = 32'd4; MDOp = 2'b00; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, Busy}, 64'd0);
    chk("midrst_hi", {32'd0, Hi}, 64'd0);
    chk("midrst_lo", {32'd0, Lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    #2 reset = 1'b0;
    do_op(2'b00, 32'd3, 32'd4, 1'b0);

    // Randomized mix of ops and HI/LO moves.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 100); rb = $urandom_range(0, 9) - 5; end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0)
        do_mt(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), ra);
      else
        do_op(2'($urandom), ra, rb, 1'($urandom_range(0, 4) == 0));
    end

    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
